// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: axis segment lengths and the axis state encoding.
package vga_pkg;

    // Raster counters are 10 bits wide; 799 and 524 both fit.
    localparam int unsigned CNT_W = 10;
    // Frames-per-game-tick counter width; GAME_DIV ranges 1..63.
    localparam int unsigned GAME_W = 6;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } axis_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a count walking ACTIVE -> FRONT -> SYNC -> BACK and wrapping to 0.
// sync_n and active are registered alongside the count so they carry no skew against it.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE = 640,
    parameter int unsigned FRONT_LEN = 16,
    parameter int unsigned SYNC_LEN = 96,
    parameter int unsigned BACK_LEN = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output axis_state_e      state,
    output logic             sync_n,
    output logic             active,
    output logic             wrap
);

    localparam int unsigned TOTAL = VISIBLE + FRONT_LEN + SYNC_LEN + BACK_LEN;

    // Last count of each segment; reaching it on a step moves to the next segment.
    localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(VISIBLE - 1);
    localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(VISIBLE + FRONT_LEN - 1);
    localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(VISIBLE + FRONT_LEN + SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] END_TOTAL  = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q;
    axis_state_e      state_q;
    logic             sync_n_q;
    logic             active_q;

    // '>=' rather than '==' so a corrupted count still wraps on the next step.
    assign wrap = (cnt_q >= END_TOTAL);

    // Axis FSM: count, segment state and the decoded sync/active flags update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            state_q  <= ACTIVE;
            sync_n_q <= 1'b1;
            active_q <= 1'b1;
        end else if (step) begin
            if (wrap) begin
                cnt_q    <= '0;
                state_q  <= ACTIVE;
                sync_n_q <= 1'b1;
                active_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                unique case (state_q)
                    ACTIVE: begin
                        if (cnt_q == END_ACTIVE) begin
                            state_q  <= FRONT;
                            active_q <= 1'b0;
                        end
                    end
                    FRONT: begin
                        if (cnt_q == END_FRONT) begin
                            state_q  <= SYNC;
                            sync_n_q <= 1'b0;
                        end
                    end
                    SYNC: begin
                        if (cnt_q == END_SYNC) begin
                            state_q  <= BACK;
                            sync_n_q <= 1'b1;
                        end
                    end
                    BACK: begin
                        state_q <= BACK;
                    end
                endcase
            end
        end
    end

    assign cnt    = cnt_q;
    assign state  = state_q;
    assign sync_n = sync_n_q;
    assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel prescaler, H/V axis counters, line/frame pulses and game tick.
// The segment lengths default to 640x480@60; they are exposed only so a reduced raster
// can be built for quick checks.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = 4,
    parameter int unsigned GAME_DIV = 1,
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP = H_FRONT,
    parameter int unsigned H_SW = H_SYNC,
    parameter int unsigned H_BP = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP = V_FRONT,
    parameter int unsigned V_SW = V_SYNC,
    parameter int unsigned V_BP = V_BACK
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_tick,
    output logic             game_tick
);

    localparam int unsigned        PRESC_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PIX_DIV - 1);
    localparam logic [GAME_W-1:0]  GAME_LAST  = GAME_W'(GAME_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic               pix_en_q;
    logic               h_wrap;
    logic               v_wrap;
    logic               v_step;
    logic               frame_evt;
    logic               h_sync_n;
    logic               v_sync_n;
    logic               h_active;
    logic               v_active;
    axis_state_e        h_state;
    axis_state_e        v_state;
    logic [GAME_W-1:0]  frame_cnt_q;
    logic               line_start_q;
    logic               frame_tick_q;
    logic               game_tick_q;

    // Registered pix_en puts the first strobe PIX_DIV clocks after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            pix_en_q <= 1'b0;
        end else begin
            pix_en_q <= (presc_q == PRESC_LAST);
            presc_q  <= (presc_q >= PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // The vertical axis advances on the pixel that wraps the line.
    assign v_step    = pix_en_q & h_wrap;
    assign frame_evt = v_step & v_wrap;

    vga_axis_counter #(
        .VISIBLE   (H_VIS),
        .FRONT_LEN (H_FP),
        .SYNC_LEN  (H_SW),
        .BACK_LEN  (H_BP)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (pix_en_q),
        .cnt    (h_cnt),
        .state  (h_state),
        .sync_n (h_sync_n),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE   (V_VIS),
        .FRONT_LEN (V_FP),
        .SYNC_LEN  (V_SW),
        .BACK_LEN  (V_BP)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (v_step),
        .cnt    (v_cnt),
        .state  (v_state),
        .sync_n (v_sync_n),
        .active (v_active),
        .wrap   (v_wrap)
    );

    // Axis states are carried for debug visibility only; the flags already decode them.
    logic unused_state;
    assign unused_state = ^{h_state, v_state};

    // Wrap pulses land in the same cycle the counters show 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            line_start_q <= v_step;
            frame_tick_q <= frame_evt;
        end
    end

    // Game divider: fires with every GAME_DIV-th frame wrap, aligned with frame_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            game_tick_q <= 1'b0;
        end else begin
            game_tick_q <= 1'b0;
            if (frame_evt) begin
                if (frame_cnt_q >= GAME_LAST) begin
                    frame_cnt_q <= '0;
                    game_tick_q <= 1'b1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + GAME_W'(1);
                end
            end
        end
    end

    assign pix_en     = pix_en_q;
    assign valid      = h_active & v_active;
    assign hsync      = h_sync_n;
    assign vsync      = v_sync_n;
    assign line_start = line_start_q;
    assign frame_tick = frame_tick_q;
    assign game_tick  = game_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size raster (PIX_DIV=4, GAME_DIV=1) and a reduced
// raster (PIX_DIV=2, GAME_DIV=3) run side by side under random reset pulses. Expected
// outputs come from an arithmetic model of the raster indexed by clocks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic       line_start;
        logic       frame_tick;
        logic       game_tick;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Full-size instance
    logic       pix_en_a, valid_a, hsync_a, vsync_a, ls_a, ft_a, gt_a;
    logic [9:0] h_a, v_a;
    // Reduced raster instance: H 8/2/3/2, V 5/1/2/2
    logic       pix_en_b, valid_b, hsync_b, vsync_b, ls_b, ft_b, gt_b;
    logic [9:0] h_b, v_b;

    vga_timing_gen #(
        .PIX_DIV  (4),
        .GAME_DIV (1)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en_a),
        .h_cnt      (h_a),
        .v_cnt      (v_a),
        .valid      (valid_a),
        .hsync      (hsync_a),
        .vsync      (vsync_a),
        .line_start (ls_a),
        .frame_tick (ft_a),
        .game_tick  (gt_a)
    );

    vga_timing_gen #(
        .PIX_DIV  (2),
        .GAME_DIV (3),
        .H_VIS    (8),
        .H_FP     (2),
        .H_SW     (3),
        .H_BP     (2),
        .V_VIS    (5),
        .V_FP     (1),
        .V_SW     (2),
        .V_BP     (2)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en_b),
        .h_cnt      (h_b),
        .v_cnt      (v_b),
        .valid      (valid_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .line_start (ls_b),
        .frame_tick (ft_b),
        .game_tick  (gt_b)
    );

    obs_t obs_a, obs_b;
    assign obs_a = {pix_en_a, h_a, v_a, valid_a, hsync_a, vsync_a, ls_a, ft_a, gt_a};
    assign obs_b = {pix_en_b, h_b, v_b, valid_b, hsync_b, vsync_b, ls_b, ft_b, gt_b};

    obs_t qa[$];
    obs_t qb[$];

    int vectors = 0;
    int miscompares = 0;

    // Expected outputs k clocks after reset release (k = 0: in or just out of reset).
    // Pixel p has been shown since the (p*d+1)-th edge; counts follow p by division.
    function automatic obs_t model(input longint k, input int unsigned d, input int unsigned g,
                                   input int unsigned hv, input int unsigned hf,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned vv, input int unsigned vf,
                                   input int unsigned vs, input int unsigned vb);
        obs_t   o;
        longint ht, vt, p, h, v, f;
        bit     stepped;
        ht = longint'(hv + hf + hs + hb);
        vt = longint'(vv + vf + vs + vb);
        p  = (k == 0) ? 0 : (k - 1) / longint'(d);
        h  = p % ht;
        v  = (p / ht) % vt;
        f  = p / (ht * vt);
        stepped      = (k >= longint'(d) + 1) && (((k - 1) % longint'(d)) == 0);
        o.pix_en     = (k >= longint'(d)) && ((k % longint'(d)) == 0);
        o.h          = 10'(h);
        o.v          = 10'(v);
        o.valid      = (h < longint'(hv)) && (v < longint'(vv));
        o.hsync      = !((h >= longint'(hv + hf)) && (h < longint'(hv + hf + hs)));
        o.vsync      = !((v >= longint'(vv + vf)) && (v < longint'(vv + vf + vs)));
        o.line_start = stepped && (h == 0);
        o.frame_tick = o.line_start && (v == 0);
        o.game_tick  = o.frame_tick && ((f % longint'(g)) == 0);
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got h=%0d v=%0d pix/val/hs/vs/ls/ft/gt=%b%b%b%b%b%b%b want h=%0d v=%0d pix/val/hs/vs/ls/ft/gt=%b%b%b%b%b%b%b",
                     name, $time, got.h, got.v, got.pix_en, got.valid, got.hsync, got.vsync,
                     got.line_start, got.frame_tick, got.game_tick, exp.h, exp.v, exp.pix_en,
                     exp.valid, exp.hsync, exp.vsync, exp.line_start, exp.frame_tick,
                     exp.game_tick);
        end
    endtask

    // Reference: track clocks since reset release and queue the expected outputs.
    // rst only changes 2 time units after a posedge, so sampling at +3 is race-free.
    longint k_cnt = 0;
    bit     last_rst = 1'b1;
    always @(posedge clk) begin
        #3;
        if (rst) k_cnt = 0;
        else if (!last_rst) k_cnt = k_cnt + 1;
        else k_cnt = 0;
        last_rst = rst;
        qa.push_back(model(k_cnt, 4, 1, 640, 16, 96, 48, 480, 10, 2, 33));
        qb.push_back(model(k_cnt, 2, 3, 8, 2, 3, 2, 5, 1, 2, 2));
    end

    // Monitor: the DUT presents a raster sample every clock; compare mid-cycle.
    always @(negedge clk) begin
        if (qa.size() > 0 && qb.size() > 0) begin
            check("dut_a", obs_a, qa.pop_front());
            check("dut_b", obs_b, qb.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        // Over two full-size lines plus many reduced frames (game divider by 3).
        repeat (7000) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #2 rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 rst = 1'b0;
            repeat ($urandom_range(200, 3000)) @(posedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        if (vectors < 12) begin
            miscompares++;
            $display("FAIL vector_count got %0d want at least 12", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
